// File: rtl/led_scroll_display.sv
// led_scroll_display: stores a column stream from the message sequencer as
// rendered glyph columns, scrolls a NUM_COLS-wide window across the stored
// message and scans it onto a column-multiplexed 8-row LED matrix.
// Optional build macro LED_ACTIVE_LOW_EN: col_sel and row_data are driven
// active-low from their output registers; all internal logic is unchanged.
module led_scroll_display #(
    parameter int NUM_COLS   = 8,
    parameter int MSG_COLS   = 64,
    parameter int SCAN_DIV   = 1000,
    parameter int SCROLL_DIV = 2500000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        write,
    input  logic [7:0]                  char_in,
    input  logic [1:0]                  column,
    output logic [NUM_COLS-1:0]         col_sel,
    output logic [7:0]                  row_data,
    output logic [$clog2(MSG_COLS):0]   msg_len,
    output logic                        busy,
    output logic                        overflow
);

    localparam int AW     = $clog2(MSG_COLS);
    localparam int LW     = AW + 1;
    localparam int KW     = $clog2(NUM_COLS);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SCRL_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

`ifdef LED_ACTIVE_LOW_EN
    localparam logic ACT_INV = 1'b1;
`else
    localparam logic ACT_INV = 1'b0;
`endif
    localparam logic [7:0]          ROW_XOR = {8{ACT_INV}};
    localparam logic [NUM_COLS-1:0] COL_XOR = {NUM_COLS{ACT_INV}};
    localparam logic [NUM_COLS-1:0] COL_RST = COL_XOR ^ NUM_COLS'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    // 3x7 glyph font; bit0 is the top row, column 3 is the inter-character gap
    function automatic logic [7:0] font_col(input logic [7:0] ch, input logic [1:0] col);
        logic [23:0] g;
        case (ch)
            8'h20: g = 24'h000000;  // ' '
            8'h2D: g = 24'h080808;  // '-'
            8'h3A: g = 24'h002400;  // ':'
            8'h28: g = 24'h003E41;  // '('
            8'h29: g = 24'h413E00;  // ')'
            8'h30: g = 24'h3E493E;
            8'h31: g = 24'h427F40;
            8'h32: g = 24'h62514E;
            8'h33: g = 24'h224936;
            8'h34: g = 24'h0F087F;
            8'h35: g = 24'h4F4931;
            8'h36: g = 24'h3E4932;
            8'h37: g = 24'h017907;
            8'h38: g = 24'h364936;
            8'h39: g = 24'h26493E;
            8'h41: g = 24'h7E097E;
            8'h42: g = 24'h7F4936;
            8'h43: g = 24'h3E4122;
            8'h44: g = 24'h7F413E;
            8'h45: g = 24'h7F4941;
            8'h46: g = 24'h7F0901;
            8'h47: g = 24'h3E417A;
            8'h48: g = 24'h7F087F;
            8'h49: g = 24'h417F41;
            8'h4A: g = 24'h20403F;
            8'h4B: g = 24'h7F0877;
            8'h4C: g = 24'h7F4040;
            8'h4D: g = 24'h7F067F;
            8'h4E: g = 24'h7F1C7F;
            8'h4F: g = 24'h3E413E;
            8'h50: g = 24'h7F0906;
            8'h51: g = 24'h3E617E;
            8'h52: g = 24'h7F1966;
            8'h53: g = 24'h464931;
            8'h54: g = 24'h017F01;
            8'h55: g = 24'h3F403F;
            8'h56: g = 24'h1F601F;
            8'h57: g = 24'h7F307F;
            8'h58: g = 24'h770877;
            8'h59: g = 24'h077807;
            8'h5A: g = 24'h714947;
            default: g = 24'h7E427E;  // unknown code: hollow box
        endcase
        case (col)
            2'd0:    font_col = g[23:16];
            2'd1:    font_col = g[15:8];
            2'd2:    font_col = g[7:0];
            default: font_col = 8'h00;
        endcase
    endfunction

    state_t                state_q, state_d;
    logic [LW-1:0]         ptr_q, ptr_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         off_q, off_d;
    logic                  ovf_q, ovf_d;
    logic [SCAN_W-1:0]     scan_cnt_q, scan_cnt_d;
    logic [SCRL_W-1:0]     scrl_cnt_q, scrl_cnt_d;
    logic [KW-1:0]         k_q, k_d;
    logic [NUM_COLS-1:0]   col_q, col_d;
    logic [7:0]            row_q, row_d;
    logic [7:0]            mem_q [MSG_COLS];
    logic                  mem_we_s;
    logic [AW-1:0]         mem_addr_s;
    logic [7:0]            font_s;
    logic                  scan_wrap_s;
    logic                  scrl_wrap_s;
    logic [31:0]           win_a_s;
    logic [7:0]            pix_s;

    // Glyph column for the incoming write
    always_comb begin
        font_s = font_col(char_in, column);
    end

    // Fill-burst FSM, write pointer, overflow flag and scroll offset
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        off_d      = off_q;
        ovf_d      = ovf_q;
        scrl_cnt_d = scrl_cnt_q;
        mem_we_s   = 1'b0;
        mem_addr_s = ptr_q[AW-1:0];
        scrl_wrap_s = (scrl_cnt_q == SCRL_W'(SCROLL_DIV - 1));
        case (state_q)
            ST_IDLE: begin
                if (write) begin
                    // burst start wins over a coincident scroll step
                    state_d    = ST_FILL;
                    ovf_d      = 1'b0;
                    mem_we_s   = 1'b1;
                    mem_addr_s = '0;
                    ptr_d      = LW'(1);
                end else if (len_q != '0) begin
                    if (scrl_wrap_s) begin
                        scrl_cnt_d = '0;
                        off_d = (off_q == len_q - LW'(1)) ? '0 : off_q + LW'(1);
                    end else begin
                        scrl_cnt_d = scrl_cnt_q + SCRL_W'(1);
                    end
                end else begin
                    scrl_cnt_d = scrl_cnt_q;
                end
            end
            ST_FILL: begin
                if (write) begin
                    if (ptr_q == LW'(MSG_COLS)) begin
                        ovf_d = 1'b1;  // pointer saturates, column dropped
                    end else begin
                        mem_we_s = 1'b1;
                        ptr_d    = ptr_q + LW'(1);
                    end
                end else begin
                    // any gap in the write stream closes the burst
                    state_d    = ST_IDLE;
                    len_d      = ptr_q;
                    off_d      = '0;
                    scrl_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Column scan: divider, scan index and one-hot column rotation
    always_comb begin
        scan_wrap_s = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        k_d         = k_q;
        col_d       = col_q;
        if (scan_wrap_s) begin
            scan_cnt_d = '0;
            k_d        = (k_q == KW'(NUM_COLS - 1)) ? '0 : k_q + KW'(1);
            col_d      = {col_q[NUM_COLS-2:0], col_q[NUM_COLS-1]};
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
    end

    // Window mapping: pixel column for the scan index taking effect next
    always_comb begin
        win_a_s = 32'(off_d) + 32'(k_d);
        if (win_a_s >= 32'(len_d)) begin
            win_a_s = win_a_s - 32'(len_d);
        end else begin
            win_a_s = win_a_s;
        end
        if ((len_d == '0) || (win_a_s >= 32'(len_d))) begin
            pix_s = 8'h00;  // empty message or message narrower than the window
        end else begin
            pix_s = mem_q[win_a_s[AW-1:0]];
        end
    end

    // Row register: blank while filling, otherwise refreshed with col_sel
    always_comb begin
        if (state_d == ST_FILL) begin
            row_d = ROW_XOR;
        end else if (scan_wrap_s) begin
            row_d = ROW_XOR ^ pix_s;
        end else begin
            row_d = row_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            len_q      <= '0;
            off_q      <= '0;
            ovf_q      <= 1'b0;
            scan_cnt_q <= '0;
            scrl_cnt_q <= '0;
            k_q        <= '0;
            col_q      <= COL_RST;
            row_q      <= ROW_XOR;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            off_q      <= off_d;
            ovf_q      <= ovf_d;
            scan_cnt_q <= scan_cnt_d;
            scrl_cnt_q <= scrl_cnt_d;
            k_q        <= k_d;
            col_q      <= col_d;
            row_q      <= row_d;
        end
    end

    // Column memory; contents are not reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_addr_s] <= font_s;
        end
    end

    assign col_sel  = col_q;
    assign row_data = row_q;
    assign msg_len  = len_q;
    assign busy     = (state_q == ST_FILL);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_led_scroll_display.sv
// Directed bench for led_scroll_display (NUM_COLS=4, MSG_COLS=16,
// SCAN_DIV=2, SCROLL_DIV=16). Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_led_scroll_display;

    logic       clk;
    logic       rst;
    logic       write;
    logic [7:0] char_in;
    logic [1:0] column;
    logic [3:0] col_sel;
    logic [7:0] row_data;
    logic [4:0] msg_len;
    logic       busy;
    logic       overflow;

    int vectors;
    int miscompares;
    int cyc;
    int end_cyc;
    logic [7:0] m_mem [16];
    int m_ptr;
    int m_len;
    bit m_ovf;
    bit m_busy;

`ifdef LED_ACTIVE_LOW_EN
    logic [7:0] ROW_X = 8'hFF;
    logic [3:0] COL_X = 4'hF;
`else
    logic [7:0] ROW_X = 8'h00;
    logic [3:0] COL_X = 4'h0;
`endif

    led_scroll_display #(
        .NUM_COLS  (4),
        .MSG_COLS  (16),
        .SCAN_DIV  (2),
        .SCROLL_DIV(16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .write   (write),
        .char_in (char_in),
        .column  (column),
        .col_sel (col_sel),
        .row_data(row_data),
        .msg_len (msg_len),
        .busy    (busy),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_col();
        logic [3:0] one;
        one = 4'b0001 << ((cyc / 2) % 4);
        check("col_sel", 32'(col_sel), 32'(COL_X ^ one));
    endtask

    task automatic check_reset_vals();
        logic [3:0] one;
        one = 4'b0001;
        check("rst_col_sel", 32'(col_sel), 32'(COL_X ^ one));
        check("rst_row_data", 32'(row_data), 32'(ROW_X));
        check("rst_msg_len", 32'(msg_len), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
    endtask

    // Step to each of the next n scan edges and check the displayed column
    task automatic scan_check(input int n);
        int k;
        int off;
        int a;
        logic [7:0] v;
        for (int i = 0; i < n; i++) begin
            tick();
            check_col();
            if (cyc % 2 != 0) begin
                tick();
                check_col();
            end
            k   = (cyc / 2) % 4;
            off = (m_len == 0) ? 0 : ((cyc - end_cyc) / 16) % m_len;
            a   = off + k;
            if (a >= m_len) a = a - m_len;
            v   = (m_len == 0 || a >= m_len) ? 8'h00 : m_mem[a];
            check("row_data", 32'(row_data), 32'(ROW_X ^ v));
        end
    endtask

    task automatic wr(input logic [7:0] ch, input logic [1:0] c, input logic [7:0] v);
        if (!m_busy) begin
            m_busy = 1'b1;
            m_ptr  = 0;
            m_ovf  = 1'b0;
        end
        if (m_ptr == 16) begin
            m_ovf = 1'b1;
        end else begin
            m_mem[m_ptr] = v;
            m_ptr++;
        end
        write   = 1'b1;
        char_in = ch;
        column  = c;
        tick();
        check("busy_fill", 32'(busy), 32'd1);
        check("overflow_fill", 32'(overflow), 32'(m_ovf));
        check("row_blank", 32'(row_data), 32'(ROW_X));
        check_col();
    endtask

    task automatic wr_char(input logic [7:0] ch, input logic [31:0] glyph);
        logic [31:0] g;
        for (int c = 0; c < 4; c++) begin
            g = glyph >> (24 - 8 * c);
            wr(ch, 2'(c), g[7:0]);
        end
    endtask

    task automatic wr_end();
        write = 1'b0;
        tick();
        m_busy  = 1'b0;
        m_len   = m_ptr;
        end_cyc = cyc;
        check("busy_end", 32'(busy), 32'd0);
        check("msg_len", 32'(msg_len), 32'(m_len));
        check("overflow_end", 32'(overflow), 32'(m_ovf));
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0; end_cyc = 0;
        m_ptr = 0; m_len = 0; m_ovf = 1'b0; m_busy = 1'b0;
        rst = 1'b1; write = 1'b0; char_in = 8'h00; column = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cyc = 0;

        // 1: reset values, then 40 idle cycles with a blank rotating scan
        check_reset_vals();
        scan_check(20);

        // 2: burst "-:" then one scan pass at offset 0
        wr_char(8'h2D, 32'h08080800);
        wr_char(8'h3A, 32'h00240000);
        wr_end();
        scan_check(4);

        // 3: eight scroll steps, offset 1..7 and back to 0 (includes wrap reads)
        scan_check(66);

        // 4: 20-column burst saturates at 16 and flags overflow
        wr_char(8'h2D, 32'h08080800);
        wr_char(8'h7F, 32'h7E427E00);
        wr_char(8'h3A, 32'h00240000);
        wr_char(8'h20, 32'h00000000);
        wr_char(8'h2D, 32'h08080800);
        wr_end();
        scan_check(4);

        // 5: unknown code renders the box glyph; new burst clears overflow
        wr_char(8'h7F, 32'h7E427E00);
        wr_end();
        scan_check(4);
        wr(8'h7F, 2'd0, 8'h7E);
        wr(8'h7F, 2'd1, 8'h42);
        wr_end();
        scan_check(20);

        // 6: reset mid-burst after three writes
        wr(8'h2D, 2'd0, 8'h08);
        wr(8'h2D, 2'd1, 8'h08);
        wr(8'h2D, 2'd2, 8'h08);
        rst = 1'b1;
        #1;
        check_reset_vals();
        write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        m_busy = 1'b0; m_len = 0; m_ptr = 0; m_ovf = 1'b0;
        check_reset_vals();
        scan_check(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
